// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined RISC-V immediate generator.
// Holds the base opcodes that are recognised, the shift funct3 codes,
// the output format encoding, and the per-word decode flags that travel
// down the pipe next to the immediate and the tag.
package imm_gen_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Decode flags carried with every result; the XLEN-wide immediate and
  // the TAG_W-wide tag are added around this in the parametrised top.
  typedef struct packed {
    fmt_e fmt;
    logic shamt;
    logic illegal;
  } dec_info_t;

  // Shift-immediate instructions reuse the I-type slot for a shift amount.
  function automatic logic isShift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SR);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder.
// Classifies a 32-bit instruction word by opcode and builds the
// sign-extended (or, for shifts, zero-extended) immediate at XLEN bits.
// Ports:
//   inst_i  32-bit instruction word
//   imm_o   XLEN-bit immediate (zero for R-type and illegal words)
//   info_o  format code, shift-amount flag and illegal flag
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output dec_info_t       info_o
);

  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  // Start from "illegal, zero immediate" and overwrite for every opcode we
  // know. The *-32 opcodes only exist on RV64, so on RV32 they fall through
  // as illegal. RV64 shifts on OP-IMM take a 6-bit shamt, the *W shifts 5.
  always_comb begin
    imm_o          = '0;
    info_o.fmt     = FMT_ILL;
    info_o.shamt   = 1'b0;
    info_o.illegal = 1'b1;
    case (opc)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        info_o.fmt     = FMT_I;
        info_o.illegal = 1'b0;
        imm_o          = XLEN'($signed(inst_i[31:20]));
      end
      OPC_OP_IMM: begin
        info_o.fmt     = FMT_I;
        info_o.illegal = 1'b0;
        if (isShift(funct3)) begin
          info_o.shamt = 1'b1;
          imm_o        = (XLEN == 64) ? XLEN'(inst_i[25:20]) : XLEN'(inst_i[24:20]);
        end else begin
          imm_o = XLEN'($signed(inst_i[31:20]));
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          info_o.fmt     = FMT_I;
          info_o.illegal = 1'b0;
          if (isShift(funct3)) begin
            info_o.shamt = 1'b1;
            imm_o        = XLEN'(inst_i[24:20]);
          end else begin
            imm_o = XLEN'($signed(inst_i[31:20]));
          end
        end
      end
      OPC_STORE: begin
        info_o.fmt     = FMT_S;
        info_o.illegal = 1'b0;
        imm_o          = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      end
      OPC_BRANCH: begin
        info_o.fmt     = FMT_B;
        info_o.illegal = 1'b0;
        imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        info_o.fmt     = FMT_U;
        info_o.illegal = 1'b0;
        imm_o          = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OPC_JAL: begin
        info_o.fmt     = FMT_J;
        info_o.illegal = 1'b0;
        imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
      end
      OPC_OP: begin
        info_o.fmt     = FMT_R;
        info_o.illegal = 1'b0;
      end
      OPC_OP_32: begin
        if (XLEN == 64) begin
          info_o.fmt     = FMT_R;
          info_o.illegal = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the decode stage.
// Decodes each accepted instruction word and presents the immediate,
// format and flags as a registered stream through a two-entry buffer
// (main + skid), so in_ready can be a register and throughput stays at one
// word per cycle. Also counts accepted illegal opcodes, saturating.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; inst_i word, tag_i sideband tag
//   out_valid/out_ready output handshake
//   imm_o, fmt_o        immediate and format code of the presented result
//   shamt_o, illegal_o  shift-amount and illegal-opcode flags
//   tag_o               tag that entered with the presented word
//   ill_cnt_o, cnt_clr  illegal-opcode counter and its synchronous clear
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             shamt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] ill_cnt_o,
  input  logic             cnt_clr
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    dec_info_t        info;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          mainEntry_q, mainEntry_d;
  entry_t          skidEntry_q, skidEntry_d;
  entry_t          newEntry;
  logic            mainValid_q, mainValid_d;
  logic            skidValid_q, skidValid_d;
  logic [CNT_W-1:0] illCnt_q, illCnt_d;
  logic [XLEN-1:0] decImm;
  dec_info_t       decInfo;
  logic            accept;
  logic            pop;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .inst_i(inst_i),
    .imm_o (decImm),
    .info_o(decInfo)
  );

  assign newEntry = '{imm: decImm, info: decInfo, tag: tag_i};

  assign in_ready = !skidValid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = mainValid_q && out_ready;

  // Buffer steering. A pop first refills main from skid (or empties main);
  // a new word then goes to main if main is free after that, otherwise it
  // parks in skid. When skid is occupied in_ready is low, so a word never
  // arrives while both entries are full.
  always_comb begin
    mainEntry_d = mainEntry_q;
    mainValid_d = mainValid_q;
    skidEntry_d = skidEntry_q;
    skidValid_d = skidValid_q;
    if (pop) begin
      if (skidValid_q) begin
        mainEntry_d = skidEntry_q;
        skidValid_d = 1'b0;
      end else begin
        mainValid_d = 1'b0;
      end
    end
    if (accept) begin
      if (!mainValid_q || (pop && !skidValid_q)) begin
        mainEntry_d = newEntry;
        mainValid_d = 1'b1;
      end else begin
        skidEntry_d = newEntry;
        skidValid_d = 1'b1;
      end
    end
  end

  // Illegal-opcode counter: a clear wins over a same-cycle increment, and
  // the count sticks at all-ones rather than wrapping.
  always_comb begin
    illCnt_d = illCnt_q;
    if (cnt_clr) begin
      illCnt_d = '0;
    end else if (accept && decInfo.illegal && (illCnt_q != {CNT_W{1'b1}})) begin
      illCnt_d = illCnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset discards anything buffered; nothing is replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainEntry_q <= '0;
      skidEntry_q <= '0;
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      illCnt_q    <= '0;
    end else begin
      mainEntry_q <= mainEntry_d;
      skidEntry_q <= skidEntry_d;
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      illCnt_q    <= illCnt_d;
    end
  end

  assign out_valid = mainValid_q;
  assign imm_o     = mainEntry_q.imm;
  assign fmt_o     = mainEntry_q.info.fmt;
  assign shamt_o   = mainEntry_q.info.shamt;
  assign illegal_o = mainEntry_q.info.illegal;
  assign tag_o     = mainEntry_q.tag;
  assign ill_cnt_o = illCnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: an RV32 instance (2-bit counter) and an RV64
// instance share the same stimulus. Expected results come from a bench-side
// decode model and travel through per-instance scoreboard queues.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic [31:0] inst;
  logic [31:0] tag;
  logic        outReady;
  logic        cntClr;

  logic        inReady32, outValid32, shamt32, illegal32;
  logic [31:0] imm32, tag32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        inReady64, outValid64, shamt64, illegal64;
  logic [63:0] imm64;
  logic [31:0] tag64;
  logic [2:0]  fmt64;
  logic [15:0] cnt64;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        sh;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady32),
    .inst_i(inst), .tag_i(tag), .out_valid(outValid32), .out_ready(outReady),
    .imm_o(imm32), .fmt_o(fmt32), .shamt_o(shamt32), .illegal_o(illegal32),
    .tag_o(tag32), .ill_cnt_o(cnt32), .cnt_clr(cntClr)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady64),
    .inst_i(inst), .tag_i(tag), .out_valid(outValid64), .out_ready(outReady),
    .imm_o(imm64), .fmt_o(fmt64), .shamt_o(shamt64), .illegal_o(illegal64),
    .tag_o(tag64), .ill_cnt_o(cnt64), .cnt_clr(cntClr)
  );

  // Reference decode, computed at 64 bits; the RV32 expectation is the low half.
  function automatic exp_t model(input logic [31:0] w, input bit x64, input logic [31:0] t);
    exp_t e;
    logic s;
    s = w[31];
    e.imm = 64'd0; e.fmt = 3'd7; e.sh = 1'b0; e.ill = 1'b1; e.tag = t;
    case (w[6:0])
      7'h03, 7'h67, 7'h73: begin e.fmt = 3'd1; e.ill = 1'b0; e.imm = {{52{s}}, w[31:20]}; end
      7'h13: begin
        e.fmt = 3'd1; e.ill = 1'b0;
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
          e.sh = 1'b1;
          e.imm = x64 ? {58'd0, w[25:20]} : {59'd0, w[24:20]};
        end else e.imm = {{52{s}}, w[31:20]};
      end
      7'h1B: if (x64) begin
        e.fmt = 3'd1; e.ill = 1'b0;
        if (w[14:12] == 3'b001 || w[14:12] == 3'b101) begin
          e.sh = 1'b1; e.imm = {59'd0, w[24:20]};
        end else e.imm = {{52{s}}, w[31:20]};
      end
      7'h23: begin e.fmt = 3'd2; e.ill = 1'b0; e.imm = {{52{s}}, w[31:25], w[11:7]}; end
      7'h63: begin e.fmt = 3'd3; e.ill = 1'b0; e.imm = {{51{s}}, w[31], w[7], w[30:25], w[11:8], 1'b0}; end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.ill = 1'b0; e.imm = {{32{s}}, w[31:12], 12'h000}; end
      7'h6F: begin e.fmt = 3'd5; e.ill = 1'b0; e.imm = {{43{s}}, w[31], w[19:12], w[20], w[30:21], 1'b0}; end
      7'h33: begin e.fmt = 3'd0; e.ill = 1'b0; end
      7'h3B: if (x64) begin e.fmt = 3'd0; e.ill = 1'b0; end
      default: begin end
    endcase
    return e;
  endfunction

  // One clock: record what the handshakes did this cycle in the scoreboards.
  task automatic tick();
    bit acc, pp;
    acc = inValid && inReady32;
    pp  = outValid32 && outReady;
    if (acc) begin
      q32.push_back(model(inst, 1'b0, tag));
      q64.push_back(model(inst, 1'b1, tag));
    end
    @(posedge clk); #1;
    if (pp && q32.size() != 0) void'(q32.pop_front());
    if (pp && q64.size() != 0) void'(q64.pop_front());
  endtask

  task automatic test_reset();
    checks++;
    if ({outValid32, outValid64, inReady32, inReady64} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL reset_handshake: got %b expected 0011", {outValid32, outValid64, inReady32, inReady64});
    end
    checks++;
    if ({imm64, fmt64, shamt64, illegal64, tag64, cnt64, cnt32} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_values: got imm=%h fmt=%0d sh=%b ill=%b tag=%h cnt=%0d/%0d expected all zero",
               imm64, fmt64, shamt64, illegal64, tag64, cnt32, cnt64);
    end
  endtask

  task automatic test_decode();
    typedef struct packed {
      int          idx;
      bit          is64;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        sh;
      logic        ill;
    } lit_t;
    logic [31:0] words[12];
    logic [63:0] cImm64[12];
    logic [31:0] cImm32[12];
    logic [4:0]  cFl64[12];
    logic [4:0]  cFl32[12];
    lit_t        lits[16];
    int idx, cyc;
    bit acc;
    words = '{32'hFFF00093, 32'h800000B7, 32'h03F09093, 32'hFE000EE3, 32'h0040006F, 32'h00000033,
              32'h0000003B, 32'h01F0909B, 32'h0000007F, 32'hFE112E23, 32'h4050D093, 32'h12345017};
    lits = '{
      '{0, 1'b0, 64'hFFFFFFFF, 3'd1, 1'b0, 1'b0},
      '{1, 1'b1, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0},
      '{1, 1'b0, 64'h80000000, 3'd4, 1'b0, 1'b0},
      '{2, 1'b1, 64'd63, 3'd1, 1'b1, 1'b0},
      '{2, 1'b0, 64'd31, 3'd1, 1'b1, 1'b0},
      '{3, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 1'b0},
      '{4, 1'b1, 64'd4, 3'd5, 1'b0, 1'b0},
      '{5, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0},
      '{6, 1'b0, 64'd0, 3'd7, 1'b0, 1'b1},
      '{6, 1'b1, 64'd0, 3'd0, 1'b0, 1'b0},
      '{7, 1'b0, 64'd0, 3'd7, 1'b0, 1'b1},
      '{7, 1'b1, 64'd31, 3'd1, 1'b1, 1'b0},
      '{8, 1'b1, 64'd0, 3'd7, 1'b0, 1'b1},
      '{9, 1'b0, 64'hFFFFFFFC, 3'd2, 1'b0, 1'b0},
      '{10, 1'b1, 64'd5, 3'd1, 1'b1, 1'b0},
      '{11, 1'b0, 64'h12345000, 3'd4, 1'b0, 1'b0}};
    for (int i = 0; i < 12; i++) begin
      cImm64[i] = 'x; cImm32[i] = 'x; cFl64[i] = 'x; cFl32[i] = 'x;
    end
    idx = 0; cyc = 0; outReady = 1'b1;
    while ((idx < 12 || q32.size() != 0) && cyc < 200) begin
      inValid = (idx < 12);
      inst    = (idx < 12) ? words[idx] : 32'd0;
      tag     = idx;
      if (outValid32) begin
        checks++;
        if (q32.size() == 0) begin
          failures++; $display("[TB] FAIL decode_sb32: got unexpected output tag=%h expected none", tag32);
        end else if ({imm32, fmt32, shamt32, illegal32, tag32} !==
                     {q32[0].imm[31:0], q32[0].fmt, q32[0].sh, q32[0].ill, q32[0].tag}) begin
          failures++;
          $display("[TB] FAIL decode_sb32: got imm=%h fmt=%0d sh=%b ill=%b tag=%0d expected imm=%h fmt=%0d sh=%b ill=%b tag=%0d",
                   imm32, fmt32, shamt32, illegal32, tag32, q32[0].imm[31:0], q32[0].fmt, q32[0].sh, q32[0].ill, q32[0].tag);
        end
        if (tag32 < 12) begin cImm32[tag32] = imm32; cFl32[tag32] = {fmt32, shamt32, illegal32}; end
      end
      if (outValid64) begin
        checks++;
        if (q64.size() == 0) begin
          failures++; $display("[TB] FAIL decode_sb64: got unexpected output tag=%h expected none", tag64);
        end else if ({imm64, fmt64, shamt64, illegal64, tag64} !==
                     {q64[0].imm, q64[0].fmt, q64[0].sh, q64[0].ill, q64[0].tag}) begin
          failures++;
          $display("[TB] FAIL decode_sb64: got imm=%h fmt=%0d sh=%b ill=%b tag=%0d expected imm=%h fmt=%0d sh=%b ill=%b tag=%0d",
                   imm64, fmt64, shamt64, illegal64, tag64, q64[0].imm, q64[0].fmt, q64[0].sh, q64[0].ill, q64[0].tag);
        end
        if (tag64 < 12) begin cImm64[tag64] = imm64; cFl64[tag64] = {fmt64, shamt64, illegal64}; end
      end
      acc = inValid && inReady32;
      tick();
      if (acc) idx++;
      cyc++;
    end
    inValid = 1'b0;
    checks++;
    if (cyc >= 200) begin
      failures++; $display("[TB] FAIL decode_timeout: got %0d cycles expected under 200", cyc);
    end
    // Hand-computed values for the named instructions.
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (lits[i].is64) begin
        if ({cImm64[lits[i].idx], cFl64[lits[i].idx]} !== {lits[i].imm, lits[i].fmt, lits[i].sh, lits[i].ill}) begin
          failures++;
          $display("[TB] FAIL decode_lit64[%0d]: got imm=%h fl=%b expected imm=%h fl=%b", lits[i].idx,
                   cImm64[lits[i].idx], cFl64[lits[i].idx], lits[i].imm, {lits[i].fmt, lits[i].sh, lits[i].ill});
        end
      end else begin
        if ({cImm32[lits[i].idx], cFl32[lits[i].idx]} !== {lits[i].imm[31:0], lits[i].fmt, lits[i].sh, lits[i].ill}) begin
          failures++;
          $display("[TB] FAIL decode_lit32[%0d]: got imm=%h fl=%b expected imm=%h fl=%b", lits[i].idx,
                   cImm32[lits[i].idx], cFl32[lits[i].idx], lits[i].imm[31:0], {lits[i].fmt, lits[i].sh, lits[i].ill});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opcs[14];
    logic [31:0] words[24];
    logic [31:0] r;
    int n, idx, cyc;
    bit acc;
    opcs = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};
    for (int ph = 0; ph < 3; ph++) begin
      n = (ph == 0) ? 4 : (ph == 1) ? 8 : 24;
      for (int i = 0; i < 24; i++) begin
        r = $urandom();
        words[i] = {r[31:7], opcs[$urandom_range(0, (ph == 1) ? 11 : 13)]};
      end
      if (ph == 0) begin
        words[0] = 32'h800000B7; words[1] = 32'hFFF00093; words[2] = 32'hFE112E23; words[3] = 32'hFE000EE3;
      end
      idx = 0; cyc = 0;
      while ((idx < n || q32.size() != 0) && cyc < 300) begin
        outReady = (ph == 0) ? (cyc >= 3) : (ph == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        inValid  = (idx < n) && (ph != 2 || $urandom_range(0, 1) == 1);
        inst     = (idx < n) ? words[idx] : 32'd0;
        tag      = ph * 1000 + idx;
        // Outputs must match the scoreboard head whenever valid, stalled or not.
        if (outValid32) begin
          checks++;
          if (q32.size() == 0) begin
            failures++; $display("[TB] FAIL b2b_sb32: got unexpected output tag=%0d expected none", tag32);
          end else if ({imm32, fmt32, shamt32, illegal32, tag32} !==
                       {q32[0].imm[31:0], q32[0].fmt, q32[0].sh, q32[0].ill, q32[0].tag}) begin
            failures++;
            $display("[TB] FAIL b2b_sb32: got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                     imm32, fmt32, tag32, q32[0].imm[31:0], q32[0].fmt, q32[0].tag);
          end
        end
        if (outValid64) begin
          checks++;
          if (q64.size() == 0) begin
            failures++; $display("[TB] FAIL b2b_sb64: got unexpected output tag=%0d expected none", tag64);
          end else if ({imm64, fmt64, shamt64, illegal64, tag64} !==
                       {q64[0].imm, q64[0].fmt, q64[0].sh, q64[0].ill, q64[0].tag}) begin
            failures++;
            $display("[TB] FAIL b2b_sb64: got imm=%h fmt=%0d tag=%0d expected imm=%h fmt=%0d tag=%0d",
                     imm64, fmt64, tag64, q64[0].imm, q64[0].fmt, q64[0].tag);
          end
        end
        if (ph == 0 && cyc == 2) begin
          checks++;
          if (inReady32 !== 1'b0 || idx != 2) begin
            failures++;
            $display("[TB] FAIL b2b_backpressure: got in_ready=%b accepted=%0d expected in_ready=0 accepted=2", inReady32, idx);
          end
        end
        acc = inValid && inReady32;
        tick();
        if (acc) idx++;
        cyc++;
      end
      inValid = 1'b0;
      checks++;
      if (cyc >= 300) begin
        failures++; $display("[TB] FAIL b2b_timeout: got %0d cycles in phase %0d expected under 300", cyc, ph);
      end
      if (ph == 1) begin
        checks++;
        if (cyc != n + 1) begin
          failures++; $display("[TB] FAIL b2b_throughput: got %0d cycles expected %0d", cyc, n + 1);
        end
      end
    end
  endtask

  task automatic test_counter();
    inValid = 1'b0; outReady = 1'b1; cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    checks++;
    if (cnt32 !== 2'd0 || cnt64 !== 16'd0) begin
      failures++; $display("[TB] FAIL cnt_clear: got %0d/%0d expected 0/0", cnt32, cnt64);
    end
    for (int k = 1; k <= 5; k++) begin
      inValid = 1'b1; inst = 32'h0000007F; tag = 500 + k;
      tick();
      checks++;
      if (cnt32 !== 2'((k > 3) ? 3 : k) || cnt64 !== 16'(k)) begin
        failures++;
        $display("[TB] FAIL cnt_sat[%0d]: got %0d/%0d expected %0d/%0d", k, cnt32, cnt64, (k > 3) ? 3 : k, k);
      end
    end
    inst = 32'hFFF00093;
    tick();
    checks++;
    if (cnt32 !== 2'd3 || cnt64 !== 16'd5) begin
      failures++; $display("[TB] FAIL cnt_legal: got %0d/%0d expected 3/5", cnt32, cnt64);
    end
    inst = 32'h0000007F; cntClr = 1'b1;
    tick();
    cntClr = 1'b0; inValid = 1'b0;
    checks++;
    if (cnt32 !== 2'd0 || cnt64 !== 16'd0) begin
      failures++; $display("[TB] FAIL cnt_clr_priority: got %0d/%0d expected 0/0", cnt32, cnt64);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_midstream();
    outReady = 1'b0; inValid = 1'b1; inst = 32'h0000007F; tag = 900;
    tick(); tick(); tick();
    checks++;
    if (outValid32 !== 1'b1 || inReady32 !== 1'b0 || cnt64 !== 16'd2) begin
      failures++;
      $display("[TB] FAIL mid_full: got out_valid=%b in_ready=%b cnt=%0d expected 1 0 2", outValid32, inReady32, cnt64);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({outValid32, outValid64, inReady32, inReady64} !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL mid_reset_hs: got %b expected 0011", {outValid32, outValid64, inReady32, inReady64});
    end
    checks++;
    if ({cnt32, cnt64, imm64, fmt64, illegal64, tag64} !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_vals: got cnt=%0d/%0d imm=%h fmt=%0d ill=%b tag=%h expected zero",
               cnt32, cnt64, imm64, fmt64, illegal64, tag64);
    end
    q32.delete(); q64.delete();
    inValid = 1'b0; outReady = 1'b1;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b1; inst = 32'hFFF00093; tag = 77;
    tick();
    inValid = 1'b0;
    checks++;
    if (outValid32 !== 1'b1 || tag32 !== 32'd77 || imm32 !== 32'hFFFFFFFF || fmt64 !== 3'd1) begin
      failures++;
      $display("[TB] FAIL mid_after: got valid=%b tag=%0d imm=%h fmt=%0d expected 1 77 ffffffff 1",
               outValid32, tag32, imm32, fmt64);
    end
    tick();
    checks++;
    if (outValid32 !== 1'b0 || outValid64 !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_no_replay: got %b%b expected 00", outValid32, outValid64);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; inValid = 1'b0; inst = 32'd0; tag = 32'd0; outReady = 1'b0; cntClr = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] decode");
    test_decode();
    $display("[TB] back to back");
    test_back_to_back();
    $display("[TB] counter");
    test_counter();
    $display("[TB] reset midstream");
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the RISC-V decode stage. It accepts full 32-bit instruction words over a valid/ready handshake and classifies each by opcode (R/I/S/B/U/J/illegal). It sign-extends the immediate to XLEN and presents the result, format and illegal flag as a registered, back-pressurable stream to the execute stage. A 2-entry output buffer (main plus skid) allows full throughput with a registered in_ready; a saturating counter tracks illegal opcodes for debug.

Parameters:
XLEN, 32, datapath width (32 or 64); selects shamt width and OP-IMM-32 legality.
TAG_W, 32, width of a sideband tag (PC) carried unchanged alongside each instruction.
CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction word offered
in_ready  output  1  block can accept a word this cycle
inst_i  input  32  full instruction word
tag_i  input  TAG_W  sideband tag
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
imm_o  output  XLEN  sign-/zero-extended immediate
fmt_o  output  3  format code: R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
shamt_o  output  1  immediate is a shift amount, zero-extended
illegal_o  output  1  opcode not recognised
tag_o  output  TAG_W  tag of the presented result
ill_cnt_o  output  CNT_W  illegal opcodes accepted since reset/clear
cnt_clr  input  1  synchronous clear of ill_cnt_o

Behaviour:
- Reset: asynchronous, active-low, on rst_n.
  - Reset values: main_valid=0, skid_valid=0, imm_o=0, fmt_o=0, shamt_o=0, illegal_o=0, tag_o=0, ill_cnt_o=0.
  - in_ready=1 once reset is asserted; it equals !skid_valid.
  - Reset mid-transfer drops all buffered entries; nothing is replayed.
- Decode (combinational, on the accepted word; opc=inst_i[6:0]):
  - I: 0000011, 0010011, 1100111, 1110011; also 0011011 when XLEN=64. imm=sext(inst[31:20]).
  - S: 0100011. imm=sext({inst[31:25],inst[11:7]}).
  - B: 1100011. imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: 0110111, 0010111. imm=sext({inst[31:12],12'b0}); XLEN=64 sign-extends bit 31.
  - J: 1101111. imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R: 0110011; also 0111011 when XLEN=64. imm=0.
  - Shift: opc 0010011 with funct3 001/101 → shamt_o=1, imm=zext(inst[24:20]) (XLEN=32) or zext(inst[25:20]) (XLEN=64). Opc 0011011 uses 5-bit shamt.
  - Other opcode, or 0011011/0111011 when XLEN=32 → fmt=7, illegal=1, imm=0.
- Handshake:
  - Accept when in_valid&&in_ready. Pop when out_valid&&out_ready. out_valid=main_valid.
  - Latency: a word accepted at edge N is presented after edge N, i.e. visible in cycle N+1.
  - Accept with main empty, or main popping the same cycle with skid empty → write main.
  - Accept with main full and not popping → write skid; in_ready falls next cycle.
  - Pop with skid full → skid moves to main, skid empties.
  - Outputs are held stable while out_valid && !out_ready.
  - Order is strictly FIFO; no word is lost or duplicated.
  - Sustained in_valid=out_ready=1 gives 1 result per cycle.
- Counter:
  - Increments on each accepted illegal word and saturates at 2^CNT_W-1.
  - cnt_clr has priority; clear and increment in the same cycle → 0.

Decomposition:
- Package imm_gen_pkg holds opcode localparams, format codes (FMT_R..FMT_ILL) and a result struct {imm, fmt, shamt, illegal, tag}.
- Sub-module imm_decode (purely combinational decode, parametrised by XLEN); the top holds the buffer, handshake and counter.

Test Plan:
- XLEN=32, inst 0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, imm_o=0xFFFFFFFF, fmt_o=1, illegal_o=0.
- XLEN=64, inst 0x800000B7 (lui) → imm_o=0xFFFFFFFF80000000, fmt_o=4; inst 0x03F09093 (slli x1,x1,63) → imm_o=63, shamt_o=1.
- Branch 0xFE000EE3 (beq offset -4) → imm_o=-4 sign-extended, fmt_o=3; jal 0x0040006F → imm_o=4, fmt_o=5.
- 4 back-to-back words with out_ready low for 3 cycles → in_ready falls after 2 accepted words; release gives results in order, none lost, then 1 per cycle.
- Opcode 0x7F repeated with CNT_W=2 → ill_cnt_o saturates at 3; cnt_clr alongside an illegal accept → 0.
- rst_n low mid-stream with both entries full → out_valid=0 immediately, in_ready=1, ill_cnt_o=0.
